// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes ALUOp/funct7/funct3, selects operand 2 and issues
// through a valid/ready output register backed by a 1-entry skid buffer.
// Optional: ALU_ISSUE_ILLEGAL_EN adds illegal_o and a saturating illegal_cnt_o.
module alu_issue_stage #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [1:0]      alu_op_i,
    input  logic [6:0]      funct7_i,
    input  logic [2:0]      funct3_i,
    input  logic            alu_src_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [RD_W-1:0] rd_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] data1_o,
    output logic [XLEN-1:0] data2_o,
    output logic [2:0]      opcode_o,
    output logic [RD_W-1:0] rd_o
`ifdef ALU_ISSUE_ILLEGAL_EN
   ,output logic            illegal_o,
    output logic [15:0]     illegal_cnt_o
`endif
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SLL = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SRA = 3'b101;
    localparam logic [2:0] OP_NOP = 3'b110;
    localparam logic [2:0] OP_AND = 3'b111;

    typedef struct packed {
        logic [2:0]      opcode;
        logic [XLEN-1:0] data1;
        logic [XLEN-1:0] data2;
        logic [RD_W-1:0] rd;
    } entry_t;

    localparam entry_t ENTRY_RST = '{opcode: OP_NOP, data1: '0, data2: '0, rd: '0};

    entry_t dec;
    entry_t out_d, out_q;
    entry_t skid_d, skid_q;
    logic   out_valid_d, out_valid_q;
    logic   skid_valid_d, skid_valid_q;
    logic   accept, out_load;
    logic [XLEN-1:0] op2;

    always_comb begin
        dec.opcode = OP_NOP;
        unique case (alu_op_i)
            2'b10: begin
                if (funct7_i == 7'b0000000) begin
                    case (funct3_i)
                        3'b000:  dec.opcode = OP_ADD;
                        3'b001:  dec.opcode = OP_SLL;
                        3'b100:  dec.opcode = OP_XOR;
                        3'b111:  dec.opcode = OP_AND;
                        default: dec.opcode = OP_NOP;
                    endcase
                end else if (funct7_i == 7'b0100000 && funct3_i == 3'b000) begin
                    dec.opcode = OP_SUB;
                end else if (funct7_i == 7'b0000001 && funct3_i == 3'b000) begin
                    dec.opcode = OP_MUL;
                end
            end
            2'b00: begin
                if (funct3_i == 3'b000)
                    dec.opcode = OP_ADD;
                else if (funct3_i == 3'b101 && funct7_i == 7'b0100000)
                    dec.opcode = OP_SRA;
            end
            2'b01:   dec.opcode = OP_ADD;
            default: dec.opcode = OP_SUB;
        endcase

        // Shift ops only see a 5-bit shamt; the upper bits would otherwise carry imm funct7.
        op2 = alu_src_i ? imm_i : rs2_data_i;
        if (dec.opcode == OP_SLL || dec.opcode == OP_SRA)
            op2 = {{(XLEN-5){1'b0}}, op2[4:0]};
        dec.data1 = rs1_data_i;
        dec.data2 = op2;
        dec.rd    = rd_i;
    end

    assign in_ready_o = ~rst_i & ~skid_valid_q;
    assign accept     = in_valid_i & in_ready_o;
    assign out_load   = ~out_valid_q | out_ready_i;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_load) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = accept;
                if (accept)
                    skid_d = dec;
            end else if (accept) begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q        <= ENTRY_RST;
            out_valid_q  <= 1'b0;
            skid_q       <= ENTRY_RST;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign data1_o     = out_q.data1;
    assign data2_o     = out_q.data2;
    assign opcode_o    = out_q.opcode;
    assign rd_o        = out_q.rd;

`ifdef ALU_ISSUE_ILLEGAL_EN
    logic        illegal_d, illegal_q;
    logic [15:0] illegal_cnt_d, illegal_cnt_q;

    always_comb begin
        illegal_d     = illegal_q;
        illegal_cnt_d = illegal_cnt_q;
        if (out_valid_d && (out_d.opcode != out_q.opcode || out_d != out_q || !out_valid_q || out_load))
            illegal_d = (out_d.opcode == OP_NOP);
        // Flush does not clear the count; a transfer in the flush cycle still counts.
        if (out_valid_q && out_ready_i && illegal_q && illegal_cnt_q != 16'hFFFF)
            illegal_cnt_d = illegal_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            illegal_q     <= 1'b0;
            illegal_cnt_q <= '0;
        end else begin
            illegal_q     <= illegal_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign illegal_o     = illegal_q;
    assign illegal_cnt_o = illegal_cnt_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage; illegal-op checks are
// compiled in when ALU_ISSUE_ILLEGAL_EN is defined.
module tb_alu_issue_stage;

    localparam int XLEN = 32;
    localparam int RD_W = 5;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            flush_i;
    logic            in_valid_i;
    logic            in_ready_o;
    logic [1:0]      alu_op_i;
    logic [6:0]      funct7_i;
    logic [2:0]      funct3_i;
    logic            alu_src_i;
    logic [XLEN-1:0] rs1_data_i;
    logic [XLEN-1:0] rs2_data_i;
    logic [XLEN-1:0] imm_i;
    logic [RD_W-1:0] rd_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [XLEN-1:0] data1_o;
    logic [XLEN-1:0] data2_o;
    logic [2:0]      opcode_o;
    logic [RD_W-1:0] rd_o;
`ifdef ALU_ISSUE_ILLEGAL_EN
    logic            illegal_o;
    logic [15:0]     illegal_cnt_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    alu_issue_stage #(.XLEN(XLEN), .RD_W(RD_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .alu_op_i(alu_op_i), .funct7_i(funct7_i), .funct3_i(funct3_i),
        .alu_src_i(alu_src_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .imm_i(imm_i), .rd_i(rd_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .data1_o(data1_o), .data2_o(data2_o), .opcode_o(opcode_o), .rd_o(rd_o)
`ifdef ALU_ISSUE_ILLEGAL_EN
       ,.illegal_o(illegal_o), .illegal_cnt_o(illegal_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic drive_op(input logic v, input logic [1:0] op, input logic [6:0] f7,
                            input logic [2:0] f3, input logic src, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] im, input logic [4:0] rd);
        in_valid_i = v;  alu_op_i = op;  funct7_i = f7;  funct3_i = f3;
        alu_src_i = src; rs1_data_i = a; rs2_data_i = b; imm_i = im; rd_i = rd;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; flush_i = 1'b0; out_ready_i = 1'b0;
        drive_op(1'b0, 2'b00, 7'h0, 3'h0, 1'b0, 0, 0, 0, 0);
        repeat (2) begin
            @(negedge clk_i);
            n_checks++;
            if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %b want 0", in_ready_o); end
        end
        n_checks++;
        if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", out_valid_o); end
        n_checks++;
        if (opcode_o !== 3'b110 || data1_o !== 0 || data2_o !== 0 || rd_o !== 0) begin
            n_fail++; $display("FAIL rst_outputs got op=%b d1=%h d2=%h rd=%0d want 110/0/0/0", opcode_o, data1_o, data2_o, rd_o);
        end
        rst_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready got %b want 1", in_ready_o); end
    endtask

    // Issue one op with out_ready=1 and check it appears one cycle later.
    task automatic issue_check(input string name, input logic [1:0] op, input logic [6:0] f7,
                               input logic [2:0] f3, input logic src, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] im, input logic [4:0] rd,
                               input logic [2:0] exp_op, input logic [31:0] exp_d2);
        out_ready_i = 1'b1;
        drive_op(1'b1, op, f7, f3, src, a, b, im, rd);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        n_checks++;
        if (out_valid_o !== 1'b1 || opcode_o !== exp_op || data1_o !== a || data2_o !== exp_d2 || rd_o !== rd) begin
            n_fail++;
            $display("FAIL %s got v=%b op=%b d1=%h d2=%h rd=%0d want 1/%b/%h/%h/%0d",
                     name, out_valid_o, opcode_o, data1_o, data2_o, rd_o, exp_op, a, exp_d2, rd);
        end
    endtask

    task automatic test_decode();
        issue_check("sub",   2'b10, 7'b0100000, 3'b000, 1'b0, 32'd9, 32'd4, 32'd77, 5'd3, 3'b010, 32'd4);
        @(negedge clk_i);
        n_checks++;
        if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL drain_empty got %b want 0", out_valid_o); end
        issue_check("srai",  2'b00, 7'b0100000, 3'b101, 1'b1, 32'h80, 32'd1, 32'h0000_0423, 5'd7, 3'b101, 32'h3);
        issue_check("sll",   2'b10, 7'b0000000, 3'b001, 1'b0, 32'h1, 32'hFFFF_FFE5, 32'd0, 5'd8, 3'b001, 32'h5);
        issue_check("add",   2'b10, 7'b0000000, 3'b000, 1'b0, 32'h10, 32'h20, 32'h99, 5'd9, 3'b000, 32'h20);
        issue_check("xor",   2'b10, 7'b0000000, 3'b100, 1'b0, 32'h11, 32'h22, 32'h0, 5'd10, 3'b100, 32'h22);
        issue_check("and",   2'b10, 7'b0000000, 3'b111, 1'b0, 32'h12, 32'h23, 32'h0, 5'd11, 3'b111, 32'h23);
        issue_check("mul",   2'b10, 7'b0000001, 3'b000, 1'b0, 32'h13, 32'h24, 32'h0, 5'd12, 3'b011, 32'h24);
        issue_check("addi",  2'b00, 7'b1010101, 3'b000, 1'b1, 32'h14, 32'h25, 32'hFFFF_FFF0, 5'd13, 3'b000, 32'hFFFF_FFF0);
        issue_check("ldst",  2'b01, 7'b0000000, 3'b010, 1'b1, 32'h15, 32'h26, 32'h40, 5'd14, 3'b000, 32'h40);
        issue_check("beq",   2'b11, 7'b0000000, 3'b000, 1'b0, 32'h16, 32'h27, 32'h8, 5'd0, 3'b010, 32'h27);
        issue_check("i_bad", 2'b00, 7'b0000000, 3'b101, 1'b1, 32'h17, 32'h28, 32'h5, 5'd1, 3'b110, 32'h5);
        @(negedge clk_i);
    endtask

    task automatic test_backpressure();
        out_ready_i = 1'b0;
        drive_op(1'b1, 2'b10, 7'h0, 3'b000, 1'b0, 32'hA, 32'h1, 0, 5'd1);
        @(negedge clk_i);
        drive_op(1'b1, 2'b10, 7'h0, 3'b000, 1'b0, 32'hB, 32'h2, 0, 5'd2);
        n_checks++;
        if (out_valid_o !== 1'b1 || data1_o !== 32'hA || in_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL bp_a_out got v=%b d1=%h rdy=%b want 1/a/1", out_valid_o, data1_o, in_ready_o);
        end
        @(negedge clk_i);
        drive_op(1'b1, 2'b10, 7'h0, 3'b000, 1'b0, 32'hC, 32'h3, 0, 5'd3);
        n_checks++;
        if (in_ready_o !== 1'b0 || data1_o !== 32'hA || rd_o !== 5'd1) begin
            n_fail++; $display("FAIL bp_skid_full got rdy=%b d1=%h rd=%0d want 0/a/1", in_ready_o, data1_o, rd_o);
        end
        @(negedge clk_i);
        n_checks++;
        if (out_valid_o !== 1'b1 || data1_o !== 32'hA || data2_o !== 32'h1 || in_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL bp_hold got v=%b d1=%h d2=%h rdy=%b want 1/a/1/0", out_valid_o, data1_o, data2_o, in_ready_o);
        end
        out_ready_i = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if (out_valid_o !== 1'b1 || data1_o !== 32'hB || in_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL bp_b_out got v=%b d1=%h rdy=%b want 1/b/1", out_valid_o, data1_o, in_ready_o);
        end
        @(negedge clk_i);
        in_valid_i = 1'b0;
        n_checks++;
        if (out_valid_o !== 1'b1 || data1_o !== 32'hC || rd_o !== 5'd3) begin
            n_fail++; $display("FAIL bp_c_out got v=%b d1=%h rd=%0d want 1/c/3", out_valid_o, data1_o, rd_o);
        end
        @(negedge clk_i);
        n_checks++;
        if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_drained got %b want 0", out_valid_o); end
    endtask

    task automatic test_flush();
        out_ready_i = 1'b0;
        drive_op(1'b1, 2'b10, 7'h0, 3'b000, 1'b0, 32'hA1, 32'h1, 0, 5'd1);
        @(negedge clk_i);
        drive_op(1'b1, 2'b10, 7'h0, 3'b000, 1'b0, 32'hB1, 32'h2, 0, 5'd2);
        @(negedge clk_i);
        drive_op(1'b1, 2'b10, 7'h0, 3'b000, 1'b0, 32'hC1, 32'h3, 0, 5'd3);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0; in_valid_i = 1'b0;
        n_checks++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || data1_o !== 32'hA1) begin
            n_fail++; $display("FAIL flush_full got v=%b rdy=%b d1=%h want 0/1/a1", out_valid_o, in_ready_o, data1_o);
        end
        out_ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        n_checks++;
        if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_no_reissue got %b want 0", out_valid_o); end
        // Flush while the input is acceptable: the same-cycle op must be dropped.
        out_ready_i = 1'b0;
        drive_op(1'b1, 2'b10, 7'h0, 3'b000, 1'b0, 32'hA2, 32'h1, 0, 5'd4);
        @(negedge clk_i);
        drive_op(1'b1, 2'b10, 7'h0, 3'b000, 1'b0, 32'hD2, 32'h5, 0, 5'd5);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if (out_valid_o !== 1'b0 || data1_o === 32'hD2) begin
            n_fail++; $display("FAIL flush_same_cycle got v=%b d1=%h want 0/not d2", out_valid_o, data1_o);
        end
    endtask

    task automatic test_illegal();
        issue_check("r_bad", 2'b10, 7'b1111111, 3'b000, 1'b0, 32'h55, 32'h66, 32'h0, 5'd6, 3'b110, 32'h66);
`ifdef ALU_ISSUE_ILLEGAL_EN
        n_checks++;
        if (illegal_o !== 1'b1 || illegal_cnt_o !== 16'd0) begin
            n_fail++; $display("FAIL illegal_flag got il=%b cnt=%0d want 1/0", illegal_o, illegal_cnt_o);
        end
`endif
        @(negedge clk_i);
`ifdef ALU_ISSUE_ILLEGAL_EN
        n_checks++;
        if (illegal_cnt_o !== 16'd1) begin n_fail++; $display("FAIL illegal_cnt got %0d want 1", illegal_cnt_o); end
`endif
        issue_check("post_bad", 2'b10, 7'b0000000, 3'b100, 1'b0, 32'h57, 32'h68, 32'h0, 5'd7, 3'b100, 32'h68);
        @(negedge clk_i);
`ifdef ALU_ISSUE_ILLEGAL_EN
        n_checks++;
        if (illegal_o !== 1'b0 || illegal_cnt_o !== 16'd1) begin
            n_fail++; $display("FAIL illegal_legal got il=%b cnt=%0d want 0/1", illegal_o, illegal_cnt_o);
        end
`endif
    endtask

    task automatic test_mid_reset();
        out_ready_i = 1'b0;
        drive_op(1'b1, 2'b10, 7'h0, 3'b000, 1'b0, 32'hE1, 32'h1, 0, 5'd9);
        @(negedge clk_i);
        rst_i = 1'b1;
        drive_op(1'b1, 2'b10, 7'h0, 3'b000, 1'b0, 32'hE2, 32'h2, 0, 5'd10);
        @(negedge clk_i);
        rst_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        n_checks++;
        if (out_valid_o !== 1'b0 || opcode_o !== 3'b110 || data1_o !== 0) begin
            n_fail++; $display("FAIL mid_reset got v=%b op=%b d1=%h want 0/110/0", out_valid_o, opcode_o, data1_o);
        end
        @(negedge clk_i);
        n_checks++;
        if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_reset_after got %b want 0", out_valid_o); end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_backpressure();
        test_flush();
        test_illegal();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
